// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MCYCLE_EARLY_EXIT_EN: early multiply exit and single-cycle divide-by-zero.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   result1_q, result1_d;
    logic [WIDTH-1:0]   result2_q, result2_d;
    logic               div_zero_q, div_zero_d;

    logic               sign1, sign2, op2_zero;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [2*WIDTH-1:0] mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff, div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next, iter_acc, prod_fix;
    logic [WIDTH-1:0]   iter_b, quo, rem, quo_fix, rem_fix;
    logic [WIDTH-1:0]   fin_r1, fin_r2;
    logic               finish;
    logic               busy, done;

    // Operand conditioning: signed ops work on magnitudes, signs reapplied at the end.
    always_comb begin
        sign1    = MCycleOp[0] & Operand1[WIDTH-1];
        sign2    = MCycleOp[0] & Operand2[WIDTH-1];
        abs1     = sign1 ? -Operand1 : Operand1;
        abs2     = sign2 ? -Operand2 : Operand2;
        op2_zero = (Operand2 == '0);
    end

    // One iteration of either algorithm plus the sign fixup of its outcome.
    always_comb begin
        mul_sum   = acc_q + (b_q[0] ? mcand_q : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = WIDTH'(div_shift - {1'b0, b_q});
        div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
        div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
        iter_acc  = is_div_q ? div_next : mul_sum;
        iter_b    = is_div_q ? b_q : (b_q >> 1);
        prod_fix  = neg_q ? -iter_acc : iter_acc;
        quo       = iter_acc[WIDTH-1:0];
        rem       = iter_acc[2*WIDTH-1:WIDTH];
        quo_fix   = neg_q ? -quo : quo;
        rem_fix   = rem_neg_q ? -rem : rem;
        fin_r1    = dz_q ? '1 : (is_div_q ? quo_fix : prod_fix[WIDTH-1:0]);
        fin_r2    = dz_q ? op1_q : (is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH]);
`ifdef MCYCLE_EARLY_EXIT_EN
        finish    = (count_q == LAST) | (~is_div_q & (iter_b == '0));
`else
        finish    = (count_q == LAST);
`endif
    end

    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        count_d    = count_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        b_d        = b_q;
        op1_d      = op1_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        dz_d       = dz_q;
        result1_d  = result1_q;
        result2_d  = result2_q;
        div_zero_d = div_zero_q;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Busy follows Start directly so the hazard unit stalls in the request cycle.
                busy = Start;
                if (Start) begin
                    is_div_d  = MCycleOp[1];
                    count_d   = '0;
                    mcand_d   = {{WIDTH{1'b0}}, abs1};
                    acc_d     = MCycleOp[1] ? {{WIDTH{1'b0}}, abs1} : '0;
                    b_d       = abs2;
                    op1_d     = Operand1;
                    neg_d     = sign1 ^ sign2;
                    rem_neg_d = sign1;
                    dz_d      = MCycleOp[1] & op2_zero;
                    state_d   = S_COMPUTE;
`ifdef MCYCLE_EARLY_EXIT_EN
                    if (MCycleOp[1] & op2_zero) begin
                        result1_d  = '1;
                        result2_d  = Operand1;
                        div_zero_d = 1'b1;
                        state_d    = S_DONE;
                    end
`endif
                end
            end
            S_COMPUTE: begin
                busy    = 1'b1;
                acc_d   = iter_acc;
                b_d     = iter_b;
                mcand_d = mcand_q << 1;
                count_d = count_q + CW'(1);
                if (finish) begin
                    result1_d  = fin_r1;
                    result2_d  = fin_r2;
                    div_zero_d = dz_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= S_IDLE;
            is_div_q   <= 1'b0;
            count_q    <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            b_q        <= '0;
            op1_q      <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            result1_q  <= '0;
            result2_q  <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            count_q    <= count_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            b_q        <= b_d;
            op1_q      <= op1_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            dz_q       <= dz_d;
            result1_q  <= result1_d;
            result2_q  <= result2_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign Result1 = result1_q;
    assign Result2 = result2_q;
    assign DivZero = div_zero_q;
    assign Busy    = busy;
    assign Done    = done;

endmodule

// File: tb/tb_mcycle_unit.sv
// Scoreboard bench for mcycle_unit (WIDTH=32): stimulus pushes expected results and
// completion cycle, a monitor pops and compares on every Done pulse.
module tb_mcycle_unit;

    localparam int W = 32;
`ifdef MCYCLE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic         dz;
        int           cyc;
    } exp_t;

    logic         CLK = 1'b0;
    logic         RESETn = 1'b0;
    logic         Start = 1'b0;
    logic [1:0]   MCycleOp = 2'b00;
    logic [W-1:0] Operand1 = '0;
    logic [W-1:0] Operand2 = '0;
    logic [W-1:0] Result1, Result2;
    logic         Busy, Done, DivZero;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    mcycle_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2),
        .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycles from Start to Done.
    function automatic int expLatency(input logic [1:0] op, input logic [W-1:0] b);
        logic [W-1:0] mag;
        int iters;
        mag = (op[0] && b[W-1]) ? -b : b;
        iters = 1;
        for (int i = 0; i < W; i++) if (mag[i]) iters = i + 1;
        if (EARLY && op[1] && b == '0) return 1;
        if (EARLY && !op[1]) return iters + 1;
        return W + 1;
    endfunction

    task automatic applyStimulus(input bit push, input bit hold, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] r1, input logic [W-1:0] r2, input logic dz);
        exp_t e;
        @(negedge CLK);
        Start = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        e.r1 = r1;
        e.r2 = r2;
        e.dz = dz;
        e.cyc = cyc + expLatency(op, b);
        if (push) sb.push_back(e);
        #1 checkOutput("busy_on_start", {63'd0, Busy}, 64'd1);
        @(negedge CLK);
        if (!hold) Start = 1'b0;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (!Done && n < 100) begin
            checkOutput("busy_during_op", {63'd0, Busy}, 64'd1);
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no Done expected Done within 100 cycles");
        end else begin
            checkOutput("busy_in_done", {63'd0, Busy}, 64'd0);
            Start = 1'b0;
            @(negedge CLK);
            checkOutput("done_pulse_len", {63'd0, Done}, 64'd0);
        end
    endtask

    always @(negedge CLK) begin
        if (RESETn && Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got Done=1 expected Done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("result1", {32'd0, Result1}, {32'd0, mon_e.r1});
                checkOutput("result2", {32'd0, Result2}, {32'd0, mon_e.r2});
                checkOutput("divzero", {63'd0, DivZero}, {63'd0, mon_e.dz});
                checkOutput("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge CLK);
        checkOutput("reset_busy", {63'd0, Busy}, 64'd0);
        checkOutput("reset_done", {63'd0, Done}, 64'd0);
        checkOutput("reset_result1", {32'd0, Result1}, 64'd0);
        checkOutput("reset_result2", {32'd0, Result2}, 64'd0);
        checkOutput("reset_divzero", {63'd0, DivZero}, 64'd0);
        RESETn = 1'b1;

        applyStimulus(1, 0, 2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        waitDone();
        applyStimulus(1, 0, 2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0);
        waitDone();
        applyStimulus(1, 0, 2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        waitDone();
        applyStimulus(1, 0, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
        waitDone();
        applyStimulus(1, 0, 2'b11, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0);
        waitDone();
        applyStimulus(1, 0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        waitDone();
        applyStimulus(1, 0, 2'b10, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1'b1);
        waitDone();
        applyStimulus(1, 0, 2'b10, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        waitDone();

        // Start held throughout; operands change mid-operation and must be ignored.
        applyStimulus(1, 1, 2'b00, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0);
        repeat (4) @(negedge CLK);
        Operand1 = 32'hDEADBEEF;
        Operand2 = 32'h00000003;
        waitDone();
        repeat (40) @(negedge CLK);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        applyStimulus(1, 0, 2'b11, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
        waitDone();

        // Abort a multiply with reset in cycle 10.
        applyStimulus(0, 0, 2'b00, 32'd3, 32'h80000000, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge CLK);
        RESETn = 1'b0;
        #1;
        checkOutput("abort_busy", {63'd0, Busy}, 64'd0);
        checkOutput("abort_done", {63'd0, Done}, 64'd0);
        checkOutput("abort_result1", {32'd0, Result1}, 64'd0);
        checkOutput("abort_result2", {32'd0, Result2}, 64'd0);
        checkOutput("abort_divzero", {63'd0, DivZero}, 64'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        applyStimulus(1, 0, 2'b00, 32'd6, 32'd7, 32'd42, 32'd0, 1'b0);
        waitDone();

        applyStimulus(1, 0, 2'b00, 32'd5, 32'd3, 32'd15, 32'd0, 1'b0);
        waitDone();
        applyStimulus(1, 0, 2'b10, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b1);
        waitDone();

        repeat (3) @(negedge CLK);
        checkOutput("sb_final", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
